dot_matrix_scanner: RTL and testbench
=====================================

DOT_MATRIX_SCANNER -- requirements
Module: dot_matrix_scanner

Interface
REQ-001 SHALL have parameter N_COLS, default 5, number of matrix columns (>=2).
REQ-002 SHALL have parameter N_ROWS, default 3, number of dots per column (>=1).
REQ-003 SHALL have parameter SCAN_DIV, default 4, clocks each column is driven (>=1).
REQ-004 SHALL have parameter BLINK_FRAMES, default 8, frames per blink phase (>=1).
REQ-005 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset: one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port load_valid, input, 1, new pattern offered.
REQ-008 SHALL have port load_ready, output, 1, shadow buffer free.
REQ-009 SHALL have port load_data, input, N_COLS*N_ROWS, pattern; column c at bits [c*N_ROWS +: N_ROWS], bit r = row r.
REQ-010 SHALL have port blink_en, input, 1, enables blink mode.
REQ-011 SHALL have port col_sel, output, N_COLS, one-hot active-high column drive.
REQ-012 SHALL have port row_data, output, N_ROWS, dots of the selected column, active-high.
REQ-013 SHALL have port frame_start, output, 1, one-cycle pulse at start of each frame.

Function
REQ-014 SHALL hold state: div_cnt (0..SCAN_DIV-1), col_idx (0..N_COLS-1), active and shadow pattern buffers, pending flag, frame counter, blank flag.
REQ-015 SHALL increment div_cnt each clock; at SCAN_DIV-1 wrap div_cnt to 0 and advance col_idx; col_idx wraps N_COLS-1 -> 0.
REQ-016 SHALL with SCAN_DIV=1 advance col_idx every clock.
REQ-017 SHALL drive col_sel combinationally as one-hot of col_idx, never all-zero, never multi-hot.
REQ-018 SHALL drive row_data combinationally as active column col_idx, forced to 0 while blank=1.
REQ-019 SHALL define a frame boundary as the edge where div_cnt=SCAN_DIV-1 and col_idx=N_COLS-1; frame_start is registered and high for exactly the one cycle after each boundary.
REQ-020 SHALL drive load_ready = NOT pending.
REQ-021 SHALL on an edge with load_valid=1 and load_ready=1 capture load_data into shadow and set pending; load_data is ignored at all other times.
REQ-022 SHALL at a frame boundary with pending=1 (pre-edge value) copy shadow to active and clear pending; the new pattern first appears in the frame marked by frame_start.
REQ-023 SHALL on acceptance at a boundary edge while pending=0 keep active unchanged, set pending, and swap at the following boundary.
REQ-024 SHALL never alter active mid-frame; every column of one frame comes from a single pattern.
REQ-025 SHALL with blink_en=1 count frame boundaries; after BLINK_FRAMES boundaries toggle blank and restart the count.
REQ-026 SHALL with blink_en=0 hold blank=0 and frame counter=0; deassertion takes effect the next clock.
REQ-027 SHALL continue scanning and pattern swaps while blank=1.

Reset
REQ-028 SHALL on rst_n=0, without a clock, clear div_cnt, col_idx, active, shadow, pending, frame counter, blank, and frame_start.
REQ-029 SHALL during reset present col_sel=1 (column 0), row_data=0, load_ready=1, frame_start=0.
REQ-030 SHALL on reset mid-operation discard any pending pattern; the first post-reset clock is div_cnt 0 -> 1 in column 0.

Verification (defaults, SCAN_DIV=4, one frame = 20 clocks)
REQ-031 SHALL cover reset: rst_n=0 -> col_sel=5'b00001, row_data=3'b000, load_ready=1, frame_start=0, immediately and without clocks.
REQ-032 SHALL cover scan: after release, col_sel steps 00001->00010->00100->01000->10000 every 4 clocks, then 00001 with frame_start=1 for one cycle, repeating every 20 clocks.
REQ-033 SHALL cover load: load 15'b101_100_011_010_001 mid-frame -> load_ready=0 next cycle, row_data=000 until next frame_start, then columns 0..4 show 001,010,011,100,101, with load_ready=1 in that cycle.
REQ-034 SHALL cover backpressure: hold load_valid with 15'h7FFF while pending -> not captured until load_ready=1, then shown all-111 one frame later.
REQ-035 SHALL cover blink with BLINK_FRAMES=2: blink_en=1 with all-111 loaded -> row_data 111 for 2 frames, 000 for 2 frames, repeat; blink_en=0 -> 111 next clock.
REQ-036 SHALL cover mid-frame async reset after a pending load: rst_n=0 -> reset values immediately; after release row_data stays 000 across the next frame_start.

Source files
------------

// File: rtl/dot_matrix_scanner.sv
// Column-multiplexed dot-matrix driver: scans one column every SCAN_DIV clocks,
// double-buffers patterns so swaps only happen at frame boundaries, and can blink.
module dot_matrix_scanner #(
  parameter int N_COLS       = 5,
  parameter int N_ROWS       = 3,
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [N_COLS*N_ROWS-1:0]   load_data,
  input  logic                       blink_en,
  output logic [N_COLS-1:0]          col_sel,
  output logic [N_ROWS-1:0]          row_data,
  output logic                       frame_start
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int PAT_W = N_COLS * N_ROWS;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [COL_W-1:0] col_idx_q, col_idx_d;
  logic [PAT_W-1:0] active_q, active_d;
  logic [PAT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             blank_q, blank_d;
  logic             frame_start_q, frame_start_d;
  logic             div_wrap;
  logic             boundary;

  always_comb begin
    div_wrap      = (div_cnt_q == DIV_LAST);
    boundary      = div_wrap && (col_idx_q == COL_LAST);
    div_cnt_d     = div_wrap ? '0 : div_cnt_q + 1'b1;
    col_idx_d     = col_idx_q;
    active_d      = active_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q;
    frame_cnt_d   = frame_cnt_q;
    blank_d       = blank_q;
    frame_start_d = boundary;

    if (div_wrap) begin
      col_idx_d = (col_idx_q == COL_LAST) ? '0 : col_idx_q + 1'b1;
    end

    // Acceptance needs pending=0 and the swap needs pending=1, so they never coincide.
    if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (load_valid && !pending_q) begin
      shadow_d  = load_data;
      pending_d = 1'b1;
    end

    if (!blink_en) begin
      frame_cnt_d = '0;
      blank_d     = 1'b0;
    end else if (boundary) begin
      if (frame_cnt_q == FRM_LAST) begin
        frame_cnt_d = '0;
        blank_d     = !blank_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      col_idx_q     <= '0;
      active_q      <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      frame_cnt_q   <= '0;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      col_idx_q     <= col_idx_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      frame_cnt_q   <= frame_cnt_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    col_sel  = '0;
    row_data = '0;
    for (int unsigned c = 0; c < N_COLS; c++) begin
      if (COL_W'(c) == col_idx_q) begin
        col_sel[c] = 1'b1;
        if (!blank_q) begin
          row_data = active_q[c*N_ROWS +: N_ROWS];
        end
      end
    end
  end

  assign load_ready  = !pending_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Scoreboard bench for dot_matrix_scanner: a cycle-count based reference model
// pushes expected outputs per clock; a monitor pops and compares them.
module tb_dot_matrix_scanner;

  localparam int C     = 5;
  localparam int R     = 3;
  localparam int D     = 4;
  localparam int BF    = 2;
  localparam int FRAME = C * D;

  logic           clk;
  logic           rst_n;
  logic           load_valid;
  logic           load_ready;
  logic [C*R-1:0] load_data;
  logic           blink_en;
  logic [C-1:0]   col_sel;
  logic [R-1:0]   row_data;
  logic           frame_start;

  dot_matrix_scanner #(
    .N_COLS(C),
    .N_ROWS(R),
    .SCAN_DIV(D),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data(load_data),
    .blink_en(blink_en),
    .col_sel(col_sel),
    .row_data(row_data),
    .frame_start(frame_start)
  );

  typedef struct {
    logic [C-1:0] cs;
    logic [R-1:0] rd;
    logic         lr;
    logic         fs;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: clocks since reset, displayed and waiting patterns.
  int unsigned    m_pos;
  logic [C*R-1:0] m_shown;
  logic [C*R-1:0] m_wait_pat;
  bit             m_waiting;
  int unsigned    m_fcnt;
  bit             m_blank;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos      = 0;
    m_shown    = '0;
    m_wait_pat = '0;
    m_waiting  = 1'b0;
    m_fcnt     = 0;
    m_blank    = 1'b0;
  endtask

  task automatic model_step(input bit v, input logic [C*R-1:0] data, input bit blink);
    exp_t        e;
    bit          bnd;
    int unsigned col;
    bnd = ((m_pos % FRAME) == FRAME - 1);
    if (bnd && m_waiting) begin
      m_shown   = m_wait_pat;
      m_waiting = 1'b0;
    end else if (v && !m_waiting) begin
      m_wait_pat = data;
      m_waiting  = 1'b1;
    end
    if (!blink) begin
      m_fcnt  = 0;
      m_blank = 1'b0;
    end else if (bnd) begin
      m_fcnt++;
      if (m_fcnt == BF) begin
        m_fcnt  = 0;
        m_blank = !m_blank;
      end
    end
    m_pos++;
    col  = (m_pos / D) % C;
    e.cs = C'(1 << col);
    e.rd = m_blank ? '0 : R'((m_shown >> (col * R)) & ((1 << R) - 1));
    e.lr = !m_waiting;
    e.fs = bnd;
    sbq.push_back(e);
  endtask

  // Called away from edges; returns at posedge+3 after the monitor has consumed the entry.
  task automatic drive_cycle(input bit v, input logic [C*R-1:0] data, input bit blink);
    load_valid = v;
    load_data  = data;
    blink_en   = blink;
    model_step(v, data, blink);
    @(posedge clk);
    #3;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col_sel"}, 32'(col_sel), 32'h1);
    check({tag, "_row_data"}, 32'(row_data), 32'h0);
    check({tag, "_load_ready"}, 32'(load_ready), 32'h1);
    check({tag, "_frame_start"}, 32'(frame_start), 32'h0);
  endtask

  task automatic do_reset(input string tag);
    check({tag, "_queue_empty"}, 32'(sbq.size()), 32'h0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs({tag, "_async"});
    @(posedge clk);
    #1;
    check_reset_outputs({tag, "_held"});
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("col_sel", 32'(col_sel), 32'(e.cs));
        check("row_data", 32'(row_data), 32'(e.rd));
        check("load_ready", 32'(load_ready), 32'(e.lr));
        check("frame_start", 32'(frame_start), 32'(e.fs));
      end
    end
  end

  initial begin
    bit          blink;
    int unsigned rst_at;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    blink_en   = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("por_async");
    @(negedge clk);
    @(posedge clk);
    #1;
    check_reset_outputs("por_held");
    @(negedge clk);
    rst_n = 1'b1;

    // Scan only, then a mid-frame load of a known pattern.
    for (int i = 0; i < 7; i++) drive_cycle(1'b0, '0, 1'b0);
    drive_cycle(1'b1, 15'b101_100_011_010_001, 1'b0);
    for (int i = 0; i < 45; i++) drive_cycle(1'b0, '0, 1'b0);

    // Backpressure: all-ones held valid while an earlier load is pending.
    drive_cycle(1'b1, 15'h0AAA, 1'b0);
    for (int i = 0; i < 35; i++) drive_cycle(1'b1, 15'h7FFF, 1'b0);
    for (int i = 0; i < 30; i++) drive_cycle(1'b0, '0, 1'b0);

    // Blink with an all-ones pattern displayed, then release mid-phase.
    for (int i = 0; i < 170; i++) drive_cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 25; i++) drive_cycle(1'b0, '0, 1'b0);

    // Mid-frame reset with a load still pending.
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b0);
    drive_cycle(1'b1, 15'h5555, 1'b0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b0);
    do_reset("mid_rst");
    for (int i = 0; i < 45; i++) drive_cycle(1'b0, '0, 1'b0);

    // Randomized traffic with one extra reset at a random point.
    blink  = 1'b0;
    rst_at = $urandom_range(500, 2500);
    for (int unsigned i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) blink = !blink;
      if (i == rst_at) do_reset("rand_rst");
      drive_cycle(($urandom_range(0, 3) == 0), (C*R)'($urandom), blink);
    end

    @(posedge clk);
    #2;
    check("queue_drained", 32'(sbq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
